// File: rtl/timing_gen.sv
// 6502 instruction timing generator: one-hot T0..T6 cycle strobes, SYNC,
// RDY stall handling, BRK6E flag and a saturating per-instruction cycle counter.
module timing_gen #(
  parameter bit STALL_WRITES = 1'b0,
  parameter int CYC_W        = 3
) (
  input  logic             PHI0,
  input  logic             _RES,
  input  logic             RDY,
  input  logic             READ,
  input  logic             SHORT,
  input  logic             LAST,
  input  logic             BRK_IN,
  output logic             T0,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             T4,
  output logic             T5,
  output logic             T6,
  output logic             SYNC,
  output logic             _ready,
  output logic             BRK6E,
  output logic [CYC_W-1:0] CYC
);

  // One-hot encoding so each strobe is a straight register bit with no decode.
  typedef enum logic [6:0] {
    ST_T0 = 7'b0000001,
    ST_T1 = 7'b0000010,
    ST_T2 = 7'b0000100,
    ST_T3 = 7'b0001000,
    ST_T4 = 7'b0010000,
    ST_T5 = 7'b0100000,
    ST_T6 = 7'b1000000
  } tstate_t;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  tstate_t          state;
  tstate_t          state_next;
  logic [6:0]       state_bits;
  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_next;
  logic             brk6e_q;
  logic             brk6e_next;
  logic             stall;

  assign stall = ~RDY & (READ | STALL_WRITES);

  always_ff @(posedge PHI0) begin
    if (!_RES) begin
      state   <= ST_T1;
      cyc_q   <= '0;
      brk6e_q <= 1'b0;
    end else begin
      state   <= state_next;
      cyc_q   <= cyc_next;
      brk6e_q <= brk6e_next;
    end
  end

  // A stalled cycle holds everything; otherwise step the T-state and counter.
  always_comb begin
    state_next = state;
    cyc_next   = cyc_q;
    brk6e_next = brk6e_q;
    if (!stall) begin
      case (state)
        ST_T1:   state_next = SHORT ? ST_T0 : ST_T2;
        ST_T2:   state_next = LAST  ? ST_T0 : ST_T3;
        ST_T3:   state_next = LAST  ? ST_T0 : ST_T4;
        ST_T4:   state_next = LAST  ? ST_T0 : ST_T5;
        ST_T5:   state_next = LAST  ? ST_T0 : ST_T6;
        ST_T6:   state_next = ST_T0;
        ST_T0:   state_next = ST_T1;
        default: state_next = ST_T1;
      endcase
      if (state_next == ST_T1) begin
        cyc_next = CYC_W'(1);
      end else if (cyc_q != CYC_MAX) begin
        cyc_next = cyc_q + CYC_W'(1);
      end
      // Leaving T6 always heads to T0, so this also clears the flag then.
      brk6e_next = (state_next == ST_T6) & BRK_IN;
    end
  end

  assign state_bits = state;
  assign T0     = state_bits[0];
  assign T1     = state_bits[1];
  assign T2     = state_bits[2];
  assign T3     = state_bits[3];
  assign T4     = state_bits[4];
  assign T5     = state_bits[5];
  assign T6     = state_bits[6];
  assign SYNC   = state_bits[1];
  assign _ready = stall & _RES;
  assign BRK6E  = brk6e_q;
  assign CYC    = cyc_q;

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: an NMOS-style instance (3-bit counter) and a
// 65C02-style instance (write stalls, 2-bit counter) share the same stimulus.
module tb_timing_gen;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b0000010;
  localparam logic [6:0] S2 = 7'b0000100;
  localparam logic [6:0] S3 = 7'b0001000;
  localparam logic [6:0] S4 = 7'b0010000;
  localparam logic [6:0] S5 = 7'b0100000;
  localparam logic [6:0] S6 = 7'b1000000;

  logic PHI0 = 1'b0;
  logic res_n, rdy, read, short_i, last_i, brk_in;

  logic [6:0] ta, tb;
  logic sync_a, ready_a, brk_a, sync_b, ready_b, brk_b;
  logic [2:0] cyc_a;
  logic [1:0] cyc_b;
  logic [12:0] obs_a;
  logic [11:0] obs_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PHI0 = ~PHI0;

  timing_gen #(.STALL_WRITES(1'b0), .CYC_W(3)) dut (
    .PHI0(PHI0), ._RES(res_n), .RDY(rdy), .READ(read), .SHORT(short_i),
    .LAST(last_i), .BRK_IN(brk_in),
    .T0(ta[0]), .T1(ta[1]), .T2(ta[2]), .T3(ta[3]), .T4(ta[4]), .T5(ta[5]), .T6(ta[6]),
    .SYNC(sync_a), ._ready(ready_a), .BRK6E(brk_a), .CYC(cyc_a)
  );

  timing_gen #(.STALL_WRITES(1'b1), .CYC_W(2)) dut_sw (
    .PHI0(PHI0), ._RES(res_n), .RDY(rdy), .READ(read), .SHORT(short_i),
    .LAST(last_i), .BRK_IN(brk_in),
    .T0(tb[0]), .T1(tb[1]), .T2(tb[2]), .T3(tb[3]), .T4(tb[4]), .T5(tb[5]), .T6(tb[6]),
    .SYNC(sync_b), ._ready(ready_b), .BRK6E(brk_b), .CYC(cyc_b)
  );

  assign obs_a = {ta, sync_a, brk_a, ready_a, cyc_a};
  assign obs_b = {tb, sync_b, brk_b, ready_b, cyc_b};

  task automatic tick();
    @(posedge PHI0);
    #1;
  endtask

  task automatic test_reset();
    res_n = 1'b0; rdy = 1'b1; read = 1'b1;
    short_i = 1'b0; last_i = 1'b0; brk_in = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (obs_a !== {S1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_bad++; $display("[TB] FAIL reset_a: got %b exp %b", obs_a, {S1, 1'b1, 1'b0, 1'b0, 3'd0});
    end
    n_cmp++;
    if (obs_b !== {S1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_bad++; $display("[TB] FAIL reset_b: got %b exp %b", obs_b, {S1, 1'b1, 1'b0, 1'b0, 2'd0});
    end
    res_n = 1'b1;
  endtask

  // Two-cycle instructions back to back; first one starts from the reset count of 0.
  task automatic test_short();
    logic [6:0] es [4];
    logic [2:0] ca [4];
    es = '{S0, S1, S0, S1};
    ca = '{3'd1, 3'd1, 3'd2, 3'd1};
    short_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (obs_a !== {es[i], es[i][1], 1'b0, 1'b0, ca[i]}) begin
        n_bad++; $display("[TB] FAIL short_a[%0d]: got %b exp %b", i, obs_a, {es[i], es[i][1], 1'b0, 1'b0, ca[i]});
      end
      n_cmp++;
      if (obs_b !== {es[i], es[i][1], 1'b0, 1'b0, ca[i][1:0]}) begin
        n_bad++; $display("[TB] FAIL short_b[%0d]: got %b exp %b", i, obs_b, {es[i], es[i][1], 1'b0, 1'b0, ca[i][1:0]});
      end
    end
    short_i = 1'b0;
  endtask

  // LAST held in T1 and T0 must be ignored; LAST in T3 ends the instruction.
  task automatic test_last_t3();
    logic       lv [4];
    logic [6:0] es [4];
    logic [2:0] ca [4];
    logic [1:0] cb [4];
    lv = '{1'b1, 1'b0, 1'b1, 1'b1};
    es = '{S2, S3, S0, S1};
    ca = '{3'd2, 3'd3, 3'd4, 3'd1};
    cb = '{2'd2, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 4; i++) begin
      last_i = lv[i];
      tick();
      n_cmp++;
      if (obs_a !== {es[i], es[i][1], 1'b0, 1'b0, ca[i]}) begin
        n_bad++; $display("[TB] FAIL last_a[%0d]: got %b exp %b", i, obs_a, {es[i], es[i][1], 1'b0, 1'b0, ca[i]});
      end
      n_cmp++;
      if (obs_b !== {es[i], es[i][1], 1'b0, 1'b0, cb[i]}) begin
        n_bad++; $display("[TB] FAIL last_b[%0d]: got %b exp %b", i, obs_b, {es[i], es[i][1], 1'b0, 1'b0, cb[i]});
      end
    end
    last_i = 1'b0;
  endtask

  // Full seven-cycle walk, without then with BRK_IN; BRK6E only in the BRK T6.
  task automatic test_brk();
    logic [6:0] es [7];
    logic [2:0] ca [7];
    logic [1:0] cb [7];
    logic       eb;
    es = '{S2, S3, S4, S5, S6, S0, S1};
    ca = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    cb = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    last_i = 1'b0;
    for (int p = 0; p < 2; p++) begin
      brk_in = (p == 1);
      for (int i = 0; i < 7; i++) begin
        tick();
        eb = (p == 1) && (i == 4);
        n_cmp++;
        if (obs_a !== {es[i], es[i][1], eb, 1'b0, ca[i]}) begin
          n_bad++; $display("[TB] FAIL brk_a[%0d/%0d]: got %b exp %b", p, i, obs_a, {es[i], es[i][1], eb, 1'b0, ca[i]});
        end
        n_cmp++;
        if (obs_b !== {es[i], es[i][1], eb, 1'b0, cb[i]}) begin
          n_bad++; $display("[TB] FAIL brk_b[%0d/%0d]: got %b exp %b", p, i, obs_b, {es[i], es[i][1], eb, 1'b0, cb[i]});
        end
      end
    end
    brk_in = 1'b0;
  endtask

  // Read stall freezes both; write stall freezes only the STALL_WRITES instance.
  task automatic test_stall();
    logic [6:0] es [3];
    logic [2:0] ca [3];
    rdy = 1'b1; read = 1'b1;
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(); else #1;
      n_cmp++;
      if (obs_a !== {S2, 1'b0, 1'b0, 1'b1, 3'd2}) begin
        n_bad++; $display("[TB] FAIL rdstall_a[%0d]: got %b exp %b", i, obs_a, {S2, 1'b0, 1'b0, 1'b1, 3'd2});
      end
      n_cmp++;
      if (obs_b !== {S2, 1'b0, 1'b0, 1'b1, 2'd2}) begin
        n_bad++; $display("[TB] FAIL rdstall_b[%0d]: got %b exp %b", i, obs_b, {S2, 1'b0, 1'b0, 1'b1, 2'd2});
      end
    end
    rdy = 1'b1; last_i = 1'b1;
    tick();
    n_cmp++;
    if (obs_a !== {S0, 1'b0, 1'b0, 1'b0, 3'd3}) begin
      n_bad++; $display("[TB] FAIL rdstall_exit_a: got %b exp %b", obs_a, {S0, 1'b0, 1'b0, 1'b0, 3'd3});
    end
    last_i = 1'b0;
    tick();
    tick();
    es = '{S3, S4, S5};
    ca = '{3'd3, 3'd4, 3'd5};
    rdy = 1'b0; read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs_a !== {es[i], 1'b0, 1'b0, 1'b0, ca[i]}) begin
        n_bad++; $display("[TB] FAIL wrstall_a[%0d]: got %b exp %b", i, obs_a, {es[i], 1'b0, 1'b0, 1'b0, ca[i]});
      end
      n_cmp++;
      if (obs_b !== {S2, 1'b0, 1'b0, 1'b1, 2'd2}) begin
        n_bad++; $display("[TB] FAIL wrstall_b[%0d]: got %b exp %b", i, obs_b, {S2, 1'b0, 1'b0, 1'b1, 2'd2});
      end
    end
    rdy = 1'b1; read = 1'b1;
  endtask

  // Reset in T4 and in a stalled BRK T6 (with RDY low) both land in T1.
  task automatic test_reset_brk();
    logic [6:0] es [5];
    logic [1:0] cb [5];
    res_n = 1'b0; brk_in = 1'b1;
    tick();
    res_n = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (obs_a !== {S4, 1'b0, 1'b0, 1'b0, 3'd3}) begin
      n_bad++; $display("[TB] FAIL brk_t4_a: got %b exp %b", obs_a, {S4, 1'b0, 1'b0, 1'b0, 3'd3});
    end
    res_n = 1'b0;
    tick();
    n_cmp++;
    if (obs_a !== {S1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_bad++; $display("[TB] FAIL rst_t4_a: got %b exp %b", obs_a, {S1, 1'b1, 1'b0, 1'b0, 3'd0});
    end
    n_cmp++;
    if (obs_b !== {S1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_bad++; $display("[TB] FAIL rst_t4_b: got %b exp %b", obs_b, {S1, 1'b1, 1'b0, 1'b0, 2'd0});
    end
    res_n = 1'b1;
    es = '{S2, S3, S4, S5, S6};
    cb = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs_b !== {es[i], 1'b0, (i == 4), 1'b0, cb[i]}) begin
        n_bad++; $display("[TB] FAIL brk2_b[%0d]: got %b exp %b", i, obs_b, {es[i], 1'b0, (i == 4), 1'b0, cb[i]});
      end
    end
    rdy = 1'b0; read = 1'b1;
    tick();
    n_cmp++;
    if (obs_a !== {S6, 1'b0, 1'b1, 1'b1, 3'd5}) begin
      n_bad++; $display("[TB] FAIL t6_hold_a: got %b exp %b", obs_a, {S6, 1'b0, 1'b1, 1'b1, 3'd5});
    end
    res_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_a !== {S6, 1'b0, 1'b1, 1'b0, 3'd5}) begin
      n_bad++; $display("[TB] FAIL rst_ready_a: got %b exp %b", obs_a, {S6, 1'b0, 1'b1, 1'b0, 3'd5});
    end
    tick();
    n_cmp++;
    if (obs_a !== {S1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_bad++; $display("[TB] FAIL rst_t6_a: got %b exp %b", obs_a, {S1, 1'b1, 1'b0, 1'b0, 3'd0});
    end
    n_cmp++;
    if (obs_b !== {S1, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_bad++; $display("[TB] FAIL rst_t6_b: got %b exp %b", obs_b, {S1, 1'b1, 1'b0, 1'b0, 2'd0});
    end
    res_n = 1'b1; rdy = 1'b1; brk_in = 1'b0;
  endtask

  // SHORT beats LAST in T1, LAST ignored in T0, SHORT ignored in T2.
  task automatic test_short_last();
    logic       sv [6];
    logic       lv [6];
    logic [6:0] es [6];
    logic [2:0] ca [6];
    logic [1:0] cb [6];
    sv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    lv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    es = '{S0, S1, S2, S3, S0, S1};
    ca = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    cb = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
    for (int i = 0; i < 6; i++) begin
      short_i = sv[i]; last_i = lv[i];
      tick();
      n_cmp++;
      if (obs_a !== {es[i], es[i][1], 1'b0, 1'b0, ca[i]}) begin
        n_bad++; $display("[TB] FAIL shlast_a[%0d]: got %b exp %b", i, obs_a, {es[i], es[i][1], 1'b0, 1'b0, ca[i]});
      end
      n_cmp++;
      if (obs_b !== {es[i], es[i][1], 1'b0, 1'b0, cb[i]}) begin
        n_bad++; $display("[TB] FAIL shlast_b[%0d]: got %b exp %b", i, obs_b, {es[i], es[i][1], 1'b0, 1'b0, cb[i]});
      end
    end
    short_i = 1'b0; last_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_short();
    test_last_t3();
    test_brk();
    test_stall();
    test_reset_brk();
    test_short_last();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Instruction timing generator for the 6502 core. Sits directly upstream of the random control logic and supplies it with the one-hot cycle strobes T0..T6, the _ready stall indicator and BRK6E.
- Advances one T-state per PHI0 cycle under control of decoder-derived end-of-instruction inputs.
- Freezes on RDY-low read cycles.
- Provides SYNC for opcode fetch and a per-instruction cycle counter for debug and verification.

Parameters:
- STALL_WRITES, 0, 1 = RDY low also stalls write cycles (65C02 behaviour); 0 = RDY stalls read cycles only (NMOS behaviour).
- CYC_W, 3, width of the CYC cycle counter output.

Ports:
- PHI0  in  1  core clock; all state updates on the rising edge.
- _RES  in  1  synchronous active-low reset.
- RDY  in  1  ready; 0 requests a stall.
- READ  in  1  current bus cycle is a read (1) or a write (0).
- SHORT  in  1  decoder: the opcode being fetched is a 2-cycle instruction. Sampled in T1 only.
- LAST  in  1  decoder: the current cycle T2..T5 is the last before T0.
- BRK_IN  in  1  decoder: a BRK/interrupt sequence is executing.
- T0, T1, T2, T3, T4, T5, T6  out  1 each  one-hot T-state strobes; exactly one is high at all times.
- SYNC  out  1  opcode fetch cycle; equals T1.
- _ready  out  1  active-low ready; 1 = current cycle is stalled.
- BRK6E  out  1  BRK sequence is in its T6 cycle.
- CYC  out  CYC_W  cycles since the last T1 entry. Saturates at 2^CYC_W-1.

Behaviour:
- Clock and reset: single clock PHI0; reset _RES is synchronous, active-low.
- Reset (_RES=0 at an edge), from any state including mid-instruction: next state T1, CYC=0, BRK6E=0. Reset has priority over every other input.
- stall = ~RDY & (READ | STALL_WRITES).
- _ready = stall. It is combinational and is forced to 0 while _RES=0.
- While stalled, the state register, CYC and BRK6E all hold.
- Transitions when not stalled:
  - T1 -> T0 if SHORT=1, else T2.
  - T2..T5 -> T0 if LAST=1, else next Tn.
  - T6 -> T0 unconditionally; LAST is ignored.
  - T0 -> T1.
- LAST is ignored in T1 and T0. SHORT is ignored outside T1.
- If SHORT and LAST are both high in T1, SHORT wins.
- SYNC = T1. The state register is one-hot, registered, with no decode glitches.
- CYC:
  - Loads 1 on entering T1.
  - Increments on every non-stalled edge otherwise.
  - Saturates at 2^CYC_W-1.
  - Reset value 0.
- BRK6E: registered.
  - Set on the edge entering T6 if BRK_IN=1.
  - Cleared on the edge leaving T6.
  - Held during stalls.
- Instruction length: SHORT gives 2 cycles (T1,T0). LAST in Tn gives n+1 cycles. The maximum is 7 (T1..T6,T0).
- Reset values after the first reset edge: T1=1, SYNC=1; T0 and T2..T6=0; BRK6E=0; CYC=0; _ready=0.

Test Plan:
- Reset then SHORT=1 in T1, RDY=1 -> state sequence T1,T0,T1,T0; CYC reads 1 in T1 and 2 in T0.
- LAST=1 asserted in T3 -> T1,T2,T3,T0,T1; exactly one T strobe high on every cycle.
- BRK_IN=1, LAST=0 throughout -> T1..T6,T0. BRK6E=1 only during T6; the T6->T0 transition is forced.
- In T2, RDY=0 with READ=1 for 3 cycles -> T2 held 4 cycles, _ready=1 for 3 cycles, CYC frozen at 2. Repeat with READ=0: no stall when STALL_WRITES=0; 3-cycle stall when STALL_WRITES=1.
- _RES=0 pulsed during T4 of a BRK sequence -> next edge gives T1, CYC=0, BRK6E=0. Reset applied with RDY=0 still forces T1 and _ready=0.
- SHORT=1 and LAST=1 together in T1 -> T0 next. LAST=1 in T0 -> T1 next, not held.
